// File: rtl/dff_syn_pkg.sv
`timescale 1ns/1ps
// dff_syn_pkg: shared default constants for the dff_syn register
package dff_syn_pkg;
    localparam int DFF_WIDTH = 1;
    localparam logic DFF_RESET_BIT = 1'b0;
endpackage

// File: rtl/dff_syn.sv
`timescale 1ns/1ps
// dff_syn: synchronous-reset D register with complemented output
module dff_syn
    import dff_syn_pkg::*;
#(
    parameter int WIDTH = DFF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{DFF_RESET_BIT}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar
);
    always_ff @(posedge clk) q <= rst ? RESET_VALUE : d;
    assign qbar = ~q;
endmodule

// File: tb/tb_dff_syn.sv
`timescale 1ns/1ps
// tb_dff_syn: randomized scoreboard bench for dff_syn at default and 8-bit widths
module tb_dff_syn;
    typedef struct {
        logic       q1;
        logic [7:0] q8;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       d1 = 1'b0;
    logic [7:0] d8 = 8'h00;
    logic       q1, qbar1;
    logic [7:0] q8, qbar8;
    exp_t       sb[$];
    int         vecs = 0;
    int         errs = 0;

    dff_syn u1 (.clk(clk), .rst(rst), .d(d1), .q(q1), .qbar(qbar1));
    dff_syn #(.WIDTH(8), .RESET_VALUE(8'hA5)) u8 (.clk(clk), .rst(rst), .d(d8), .q(q8), .qbar(qbar8));

    always #0.5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: each edge captures RESET_VALUE under reset, otherwise the d present at the edge
    always @(posedge clk) begin
        exp_t e;
        e.q1 = rst ? 1'b0 : d1;
        e.q8 = rst ? 8'hA5 : d8;
        sb.push_back(e);
    end

    initial forever begin
        exp_t e;
        @(posedge clk);
        #0.25;
        if (sb.size() == 0) begin
            vecs++;
            errs++;
            $display("FAIL sb_empty at %0t: got 0 entries, expected 1", $time);
        end else begin
            e = sb.pop_front();
            chk("q1", {7'b0, q1}, {7'b0, e.q1});
            chk("qbar1", {7'b0, qbar1}, {7'b0, ~e.q1});
            chk("q8", q8, e.q8);
            chk("qbar8", qbar8, ~e.q8);
        end
    end

    task automatic drive(input logic r, input logic v1, input logic [7:0] v8, input bit glitch);
        @(negedge clk);
        rst = r;
        if (glitch) begin
            d1 = ~v1;
            d8 = ~v8;
            #0.1;
            d1 = v1;
            d8 = 8'($urandom);
            #0.1;
            d1 = ~v1;
            #0.1;
        end
        d1 = v1;
        d8 = v8;
    endtask

    initial begin
        logic v;
        for (int i = 0; i < 4; i++) drive(1'b1, 1'(i), 8'($urandom), 1'b0);
        drive(1'b0, 1'b1, 8'h3C, 1'b0);
        drive(1'b0, 1'b0, 8'hC3, 1'b0);
        v = d1;
        for (int i = 0; i < 4; i++) begin
            v = ~v;
            repeat ($urandom_range(1, 3)) drive(1'b0, v, 8'($urandom), 1'b0);
        end
        drive(1'b0, 1'b1, 8'h11, 1'b0);
        @(negedge clk);
        #0.25;
        rst = 1'b1;
        #0.1;
        chk("s4_hold_q1", {7'b0, q1}, 8'h01);
        chk("s4_hold_q8", q8, 8'h11);
        drive(1'b1, 1'b1, 8'hFF, 1'b0);
        drive(1'b0, 1'b1, 8'h5A, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 200; i++)
            drive(1'(($urandom_range(0, 9)) == 0), 1'($urandom), 8'($urandom), 1'($urandom));
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/dff_syn.md
DFF_SYN -- requirements
Module: dff_syn

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter WIDTH, default 1: bit width of d, q and qbar.
REQ-003 Parameter RESET_VALUE, default all-zeros (WIDTH bits): value loaded into q by reset.
REQ-004 Port clk, input, 1: clock; all state changes occur only on its rising edge.
REQ-005 Port rst, input, 1: synchronous reset, active-high; sampled only on the rising edge of clk.
REQ-006 Port d, input, WIDTH: data input, sampled on the rising edge of clk.
REQ-007 Port q, output, WIDTH: registered data output.
REQ-008 Port qbar, output, WIDTH: bitwise complement of q.

Function
REQ-009 Rising clk edge with rst=1 SHALL set q to RESET_VALUE, regardless of d.
REQ-010 Rising clk edge with rst=0 SHALL set q to the value of d sampled at that edge.
REQ-011 Latency from d to q SHALL be exactly one rising edge, with no combinational path from d to q or qbar.
REQ-012 qbar SHALL equal ~q at all times, derived from the same register with no extra cycle of delay.
REQ-013 q SHALL hold its value between rising edges; changes of d or rst between edges SHALL have no effect until the next rising edge.
REQ-014 Multiple d toggles within one clock period SHALL be invisible; only the value present at the edge is captured.
REQ-015 Asserting rst while d toggles SHALL keep q at RESET_VALUE for every edge at which rst=1.
REQ-016 Deassertion of rst SHALL take effect at the first rising edge at which rst=0, when q captures d.
REQ-017 Power-up value of q before the first rising edge is unspecified; q SHALL be defined after the first rising edge, whether reset or load.

Reset
REQ-018 Reset SHALL be fully synchronous: no reset term in the sensitivity list, and rst alone SHALL never change q.
REQ-019 Reset SHALL have priority over data load at the same edge.
REQ-020 After reset, q SHALL equal RESET_VALUE and qbar SHALL equal ~RESET_VALUE (all-ones for defaults).

Structure
REQ-021 Default WIDTH and RESET_VALUE constants SHALL reside in the shared project package; the module SHALL reference them for its parameter defaults.
REQ-022 No sub-module is needed: the block is a single clocked register process plus one continuous assignment for qbar.
REQ-023 The block SHALL be synthesizable with no latches, no initial blocks and no delays.

Verification
REQ-024 The bench SHALL use a 1 ns clock period with stimulus changing only on falling edges, so no d-to-clk race occurs.
REQ-025 Scenario 1: rst=1, d toggled 0/1 over several cycles -> q=0 and qbar=1 at every edge.
REQ-026 Scenario 2: rst=0, d=1 applied at a falling edge -> q=1 and qbar=0 after the next rising edge; then d=0 -> q=0 one edge later.
REQ-027 Scenario 3: rst=0, d held for random 1-3 ns between toggles over 4 toggles -> q equals d delayed to the next rising edge at every edge.
REQ-028 Scenario 4: rst=0, d=1, q=1, then rst=1 asserted mid-period -> q stays 1 until the next rising edge, then becomes 0.
REQ-029 Scenario 5: rst=1 and d=1 at the same edge, then rst=0 -> q=0 at that edge and q=1 at the following edge.
REQ-030 Scenario 6: WIDTH=8 and RESET_VALUE=8'hA5, rst=1 -> q=8'hA5 and qbar=8'h5A; then d=8'h3C with rst=0 -> q=8'h3C after one edge.
